seg7_scan_595: RTL and testbench

Parametrised multiplexed 7-segment scanner. It drives a chain of two 74HC595 shift registers (select byte plus segment byte) directly, with no external SPI master. It scans DIGITS hex digits and adds full 0–F decoding, per-digit decimal point and blanking, a programmable shift-clock divider, a programmable per-digit dwell time and a scan enable. It sits between the numeric datapath (BCD/hex digit registers) and the board's serial display pins.

---
 rtl/seg7_scan_595_if.sv | 45 ++++
 rtl/seg7_scan_595.sv | 187 ++++++++++++++++++
 tb/tb_seg7_scan_595.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_595_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_595_if
// Bundle between the numeric datapath and the 7-segment scanner.
//   enable      scan enable (level)
//   digits      4*DIGITS bits, nibble i is the value of digit i
//   dp_en       DIGITS bits, 1 lights the decimal point of digit i
//   blank       DIGITS bits, 1 switches digit i fully off
//   Sftclk      74HC595 shift clock
//   Lchclk      74HC595 storage (latch) clock
//   SDout       74HC595 serial data
//   Srst_n      74HC595 master reset, active low
//   cur_digit   index of the digit being shifted / currently latched
//   frame_done  one-cycle pulse at the end of the last digit's dwell
//
// Handshake: there is no valid/ready pair. enable is a level that the scanner
// samples only while idle and at the end of each dwell; digits/dp_en/blank are
// sampled in the single LOAD cycle of each digit, so the datapath may update
// them at any time and the change shows up on the next digit load.
// ---------------------------------------------------------------------------
interface seg7_scan_595_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     dp_en;
  logic [DIGITS-1:0]     blank;
  logic                  Sftclk;
  logic                  Lchclk;
  logic                  SDout;
  logic                  Srst_n;
  logic [2:0]            cur_digit;
  logic                  frame_done;

  // Datapath side.
  modport master (
    output enable, digits, dp_en, blank,
    input  Sftclk, Lchclk, SDout, Srst_n, cur_digit, frame_done
  );

  // Scanner side.
  modport slave (
    input  enable, digits, dp_en, blank,
    output Sftclk, Lchclk, SDout, Srst_n, cur_digit, frame_done
  );
endinterface

// File: rtl/seg7_scan_595.sv
// ---------------------------------------------------------------------------
// seg7_scan_595
// Multiplexed 7-segment scanner driving two chained 74HC595s (select byte
// first, segment byte second) by bit-banging their shift/latch pins.
// Each digit: LOAD (1 cycle) -> SHIFT (16 bits, 2*SCK_DIV cycles each)
// -> LATCH (SCK_DIV cycles) -> DWELL (DWELL cycles).
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   io_disp      seg7_scan_595_if.slave (inputs + 595 pins, see interface)
//   o_dbg_state  current FSM state (IDLE=0, LOAD=1, SHIFT=2, LATCH=3, DWELL=4)
// ---------------------------------------------------------------------------
module seg7_scan_595 #(
  parameter int DIGITS  = 4,
  parameter int SCK_DIV = 2,
  parameter int DWELL   = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  seg7_scan_595_if.slave         io_disp,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DWELL = 3'd4
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(SCK_DIV - 1);
  localparam logic [19:0] DWELL_LAST = 20'(DWELL - 1);
  localparam logic [2:0]  DIG_LAST   = 3'(DIGITS - 1);

  state_t      r_state;
  logic [15:0] r_sh;          // r_sh[15] is the bit currently on SDout
  logic [7:0]  r_div_cnt;
  logic [3:0]  r_bit_cnt;
  logic [19:0] r_dwell_cnt;
  logic        r_sftclk;
  logic        r_lchclk;
  logic        r_srst_n;
  logic        r_frame_done;
  logic [2:0]  r_cur;

  // Inputs padded to the 8-digit maximum so the per-digit selects below have
  // the same index width for every DIGITS value.
  logic [31:0] w_digits_pad;
  logic [7:0]  w_dp_pad;
  logic [7:0]  w_blank_pad;
  logic [3:0]  w_nib;
  logic [7:0]  w_seg;
  logic [7:0]  w_sel;
  logic [15:0] w_word;
  logic        w_last_digit;

  always_comb begin
    w_digits_pad = 32'(io_disp.digits);
    w_dp_pad     = 8'(io_disp.dp_en);
    w_blank_pad  = 8'(io_disp.blank);
    w_nib        = w_digits_pad[{r_cur, 2'b00} +: 4];
    // Digit 0 is wired to the highest select output in use.
    w_sel        = 8'd1 << (DIG_LAST - r_cur);
    w_seg        = 8'hFF;
    // Active-low segments, bit0 = a ... bit6 = g, bit7 = DP.
    case (w_nib)
      4'h0:    w_seg = 8'hC0;
      4'h1:    w_seg = 8'hF9;
      4'h2:    w_seg = 8'hA4;
      4'h3:    w_seg = 8'hB0;
      4'h4:    w_seg = 8'h99;
      4'h5:    w_seg = 8'h92;
      4'h6:    w_seg = 8'h82;
      4'h7:    w_seg = 8'hF8;
      4'h8:    w_seg = 8'h80;
      4'h9:    w_seg = 8'h90;
      4'hA:    w_seg = 8'h88;
      4'hB:    w_seg = 8'h83;
      4'hC:    w_seg = 8'hC6;
      4'hD:    w_seg = 8'hA1;
      4'hE:    w_seg = 8'h86;
      default: w_seg = 8'h8E;
    endcase
    if (w_dp_pad[r_cur]) begin
      w_seg[7] = 1'b0;
    end
    // Blanking wins over the decimal point.
    if (w_blank_pad[r_cur]) begin
      w_seg = 8'hFF;
    end
    w_word       = {w_sel, w_seg};
    w_last_digit = (r_cur == DIG_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sh         <= '0;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_dwell_cnt  <= '0;
      r_sftclk     <= 1'b0;
      r_lchclk     <= 1'b0;
      r_srst_n     <= 1'b0;
      r_frame_done <= 1'b0;
      r_cur        <= '0;
    end else begin
      r_srst_n <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (io_disp.enable) begin
            r_cur   <= '0;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Loading r_sh puts the select MSB on SDout for the first low phase.
          r_sh      <= w_word;
          r_sftclk  <= 1'b0;
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_state   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (!r_sftclk) begin
              r_sftclk <= 1'b1;
            end else begin
              // Falling edge: data only moves while Sftclk is low.
              r_sftclk <= 1'b0;
              if (r_bit_cnt == 4'd15) begin
                r_lchclk <= 1'b1;
                r_state  <= S_LATCH;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_sh      <= {r_sh[14:0], 1'b0};
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        S_LATCH: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt    <= '0;
            r_lchclk     <= 1'b0;
            r_dwell_cnt  <= '0;
            // With a one-cycle dwell the first dwell cycle is also the last.
            r_frame_done <= w_last_digit && (DWELL_LAST == 20'd0);
            r_state      <= S_DWELL;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        S_DWELL: begin
          if (r_dwell_cnt == DWELL_LAST) begin
            r_frame_done <= 1'b0;
            r_cur        <= w_last_digit ? 3'd0 : r_cur + 3'd1;
            r_state      <= io_disp.enable ? S_LOAD : S_IDLE;
          end else begin
            r_dwell_cnt  <= r_dwell_cnt + 20'd1;
            // Raised one cycle early so the pulse covers the last dwell cycle.
            r_frame_done <= w_last_digit && ((r_dwell_cnt + 20'd1) == DWELL_LAST);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_disp.Sftclk     = r_sftclk;
  assign io_disp.Lchclk     = r_lchclk;
  assign io_disp.SDout      = r_sh[15];
  assign io_disp.Srst_n     = r_srst_n;
  assign io_disp.cur_digit  = r_cur;
  assign io_disp.frame_done = r_frame_done;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_seg7_scan_595.sv
module tb_seg7_scan_595;

  // Three instances: main (a), single-digit sweep (b), eight-digit sweep (c).
  localparam int DA = 4, SA = 1, WA = 4;
  localparam int DB = 1, SB = 3, WB = 5;
  localparam int DC = 8, SC = 3, WC = 3;
  localparam int PER_A = 1 + 33 * SA + WA;   // 38-cycle digit period

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  seg7_scan_595_if #(.DIGITS(DA)) if_a ();
  seg7_scan_595_if #(.DIGITS(DB)) if_b ();
  seg7_scan_595_if #(.DIGITS(DC)) if_c ();
  logic [2:0] st_a, st_b, st_c;

  seg7_scan_595 #(.DIGITS(DA), .SCK_DIV(SA), .DWELL(WA)) u_a (
    .clk(clk), .rst(rst_a), .io_disp(if_a), .o_dbg_state(st_a));
  seg7_scan_595 #(.DIGITS(DB), .SCK_DIV(SB), .DWELL(WB)) u_b (
    .clk(clk), .rst(rst_b), .io_disp(if_b), .o_dbg_state(st_b));
  seg7_scan_595 #(.DIGITS(DC), .SCK_DIV(SC), .DWELL(WC)) u_c (
    .clk(clk), .rst(rst_c), .io_disp(if_c), .o_dbg_state(st_c));

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [15:0] model_word(input int idx, input logic [31:0] dg,
                                             input logic [7:0] dp, input logic [7:0] bl,
                                             input int nd);
    logic [7:0] seg;
    logic [7:0] sel;
    int         nib;
    nib = int'((dg >> (4 * idx)) & 32'hF);
    sel = 8'(32'd1 << (nd - 1 - idx));
    seg = seg_tab[nib];
    if (dp[idx]) seg = seg & 8'h7F;
    if (bl[idx]) seg = 8'hFF;
    return {sel, seg};
  endfunction

  // ---------------- scoreboard / checks ----------------
  logic [15:0] exp_q[$];          // expected words for instance a
  int unsigned lch_cyc_q[$];      // latch rise times of instance a
  logic [15:0] cap_b[$], cap_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- pin monitor ----------------
  logic [2:0] m_sft, m_lch, m_sd, m_fd, m_rst;
  logic [2:0] p_sft = '0, p_lch = '0, p_sd = '0, p_fd = '0;
  int          sft_run[3], lch_run[3], nbits[3], latch_cnt[3], rise_cnt[3], fd_cnt[3], viol[3];
  int unsigned last_fd_cyc[3];
  logic [15:0] acc[3];

  assign m_sft = {if_c.Sftclk, if_b.Sftclk, if_a.Sftclk};
  assign m_lch = {if_c.Lchclk, if_b.Lchclk, if_a.Lchclk};
  assign m_sd  = {if_c.SDout, if_b.SDout, if_a.SDout};
  assign m_fd  = {if_c.frame_done, if_b.frame_done, if_a.frame_done};
  assign m_rst = {rst_c, rst_b, rst_a};

  function automatic int div_of(input int k);
    return (k == 0) ? SA : ((k == 1) ? SB : SC);
  endfunction

  function automatic logic [2:0] st_of(input int k);
    return (k == 0) ? st_a : ((k == 1) ? st_b : st_c);
  endfunction

  task automatic record_word(input int k, input logic [15:0] w);
    if (k == 0) begin
      lch_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_word: got %h, required no word (nothing expected)", w);
      end else begin
        check("a_word", w, exp_q.pop_front());
      end
    end else if (k == 1) begin
      cap_b.push_back(w);
    end else begin
      cap_c.push_back(w);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (m_rst[k]) begin
        nbits[k] = 0; acc[k] = '0; sft_run[k] = 0; lch_run[k] = 0;
      end else begin
        if (m_sft[k] && m_lch[k]) begin
          viol[k]++;
          $display("protocol note: dut %0d Sftclk and Lchclk high together", k);
        end
        if (m_sft[k] && (m_sd[k] != p_sd[k])) begin
          viol[k]++;
          $display("protocol note: dut %0d SDout moved while Sftclk high", k);
        end
        if (m_sft[k] != p_sft[k]) begin
          if (p_sft[k]) check("sft_high_len", sft_run[k], div_of(k));
          else if (nbits[k] > 0 && nbits[k] < 16) check("sft_low_len", sft_run[k], div_of(k));
          sft_run[k] = 1;
          if (m_sft[k]) begin
            acc[k] = {acc[k][14:0], m_sd[k]};
            nbits[k]++;
            rise_cnt[k]++;
          end
        end else begin
          sft_run[k]++;
        end
        if (m_lch[k] && !p_lch[k]) begin
          check("latch_after_16_bits", nbits[k], 16);
          latch_cnt[k]++;
          nbits[k]   = 0;
          lch_run[k] = 1;
          record_word(k, acc[k]);
        end else if (m_lch[k]) begin
          lch_run[k]++;
        end else if (p_lch[k]) begin
          check("latch_len", lch_run[k], div_of(k));
        end
        if (m_fd[k]) begin
          fd_cnt[k]++;
          last_fd_cyc[k] = cyc;
          if (p_fd[k]) begin
            viol[k]++;
            $display("protocol note: dut %0d frame_done wider than one cycle", k);
          end
        end
      end
    end
    p_sft = m_sft; p_lch = m_lch; p_sd = m_sd; p_fd = m_fd;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_latch(input int k, input int target, input int budget);
    int n = 0;
    while (latch_cnt[k] < target && n < budget) begin tick(); n++; end
    check("wait_latch_in_time", 32'(latch_cnt[k] >= target), 1);
  endtask

  task automatic wait_fd(input int k, input int budget);
    int n = 0;
    while (!m_fd[k] && n < budget) begin tick(); n++; end
    check("wait_frame_done_in_time", 32'(m_fd[k]), 1);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    while (st_of(k) != 3'd0 && n < budget) begin tick(); n++; end
    check("wait_idle_in_time", 32'(st_of(k) == 3'd0), 1);
  endtask

  task automatic wait_nbits(input int k, input int target, input int budget);
    int n = 0;
    while (nbits[k] < target && n < budget) begin tick(); n++; end
    check("wait_bits_in_time", 32'(nbits[k] >= target), 1);
  endtask

  // One full frame on instance a starting from IDLE, with timing checks.
  task automatic run_frame_a(input logic [15:0] dg, input logic [3:0] dp,
                             input logic [3:0] bl, input logic [63:0] words);
    int          fd0;
    int unsigned t0;
    if_a.digits = dg;
    if_a.dp_en  = dp;
    if_a.blank  = bl;
    for (int i = 0; i < 4; i++) exp_q.push_back(words[16*i +: 16]);
    lch_cyc_q.delete();
    fd0 = fd_cnt[0];
    t0  = cyc;
    if_a.enable = 1'b1;
    wait_fd(0, 400);
    if_a.enable = 1'b0;
    wait_idle(0, 100);
    check("a_queue_drained", exp_q.size(), 0);
    check("a_frame_done_once", fd_cnt[0] - fd0, 1);
    check("a_cur_wrapped", if_a.cur_digit, 0);
    check("a_frame_done_time", last_fd_cyc[0] - t0, 4 * PER_A);
    check("a_latch_count", lch_cyc_q.size(), 4);
    if (lch_cyc_q.size() == 4) begin
      check("a_first_latch_delay", lch_cyc_q[0] - t0, 2 + 32 * SA);
      for (int i = 1; i < 4; i++) check("a_digit_period", lch_cyc_q[i] - lch_cyc_q[i-1], PER_A);
    end
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [15:0] dg;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic [63:0] words;   // digit 0 word in [15:0]
  } vec_t;
  vec_t vecs[4];

  initial begin
    int          base, rises0;
    logic [31:0] dg;
    logic [7:0]  dp, bl;

    vecs[0] = '{16'h3210, 4'b0000, 4'b0000, {16'h01B0, 16'h02A4, 16'h04F9, 16'h08C0}};
    vecs[1] = '{16'hFA95, 4'b0010, 4'b0100, {16'h018E, 16'h02FF, 16'h0410, 16'h0892}};
    vecs[2] = '{16'hEDCB, 4'b1111, 4'b0000, {16'h0106, 16'h0221, 16'h0446, 16'h0803}};
    vecs[3] = '{16'h8764, 4'b0001, 4'b1000, {16'h01FF, 16'h02F8, 16'h0482, 16'h0819}};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.enable = 1'b0; if_a.digits = '0; if_a.dp_en = '0; if_a.blank = '0;
    if_b.enable = 1'b0; if_b.digits = '0; if_b.dp_en = '0; if_b.blank = '0;
    if_c.enable = 1'b0; if_c.digits = '0; if_c.dp_en = '0; if_c.blank = '0;

    // Reset / defaults
    repeat (3) tick();
    check("rst_srst_n_a", if_a.Srst_n, 0);
    check("rst_sftclk_a", if_a.Sftclk, 0);
    check("rst_lchclk_a", if_a.Lchclk, 0);
    check("rst_sdout_a", if_a.SDout, 0);
    check("rst_cur_a", if_a.cur_digit, 0);
    check("rst_fd_a", if_a.frame_done, 0);
    check("rst_srst_n_b", if_b.Srst_n, 0);
    check("rst_srst_n_c", if_c.Srst_n, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    check("srst_n_after_a", if_a.Srst_n, 1);
    check("srst_n_after_b", if_b.Srst_n, 1);
    check("srst_n_after_c", if_c.Srst_n, 1);
    rises0 = rise_cnt[0];
    repeat (20) tick();
    check("idle_no_sftclk_edges", rise_cnt[0] - rises0, 0);
    check("idle_sftclk_low", if_a.Sftclk, 0);

    // Table-driven frames with hand-derived words
    for (int v = 0; v < 4; v++) run_frame_a(vecs[v].dg, vecs[v].dp, vecs[v].bl, vecs[v].words);

    // Randomized frames against the reference model
    for (int r = 0; r < 8; r++) begin
      logic [63:0] w;
      dg = $urandom;
      dp = 8'($urandom_range(0, 15));
      bl = 8'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < 4; i++) w[16*i +: 16] = model_word(i, {16'h0, dg[15:0]}, dp, bl, DA);
      run_frame_a(dg[15:0], dp[3:0], bl[3:0], w);
    end

    // Enable dropped during bit 5 of digit 1
    dg = $urandom; dp = 8'($urandom_range(0, 15)); bl = 8'h0;
    if_a.digits = dg[15:0]; if_a.dp_en = dp[3:0]; if_a.blank = bl[3:0];
    base = latch_cnt[0];
    exp_q.push_back(model_word(0, {16'h0, dg[15:0]}, dp, bl, DA));
    exp_q.push_back(model_word(1, {16'h0, dg[15:0]}, dp, bl, DA));
    if_a.enable = 1'b1;
    wait_latch(0, base + 1, 200);
    wait_nbits(0, 5, 100);
    if_a.enable = 1'b0;
    wait_idle(0, 200);
    check("drop_latches", latch_cnt[0] - base, 2);
    check("drop_cur_digit", if_a.cur_digit, 2);
    check("drop_queue_drained", exp_q.size(), 0);
    repeat (60) tick();
    check("drop_no_more_latch", latch_cnt[0] - base, 2);
    check("drop_lchclk_low", if_a.Lchclk, 0);

    // Reset asserted during bit 9
    dg = $urandom; dp = 8'($urandom_range(0, 15)); bl = 8'($urandom_range(0, 15));
    if_a.digits = dg[15:0]; if_a.dp_en = dp[3:0]; if_a.blank = bl[3:0];
    base = latch_cnt[0];
    if_a.enable = 1'b1;
    wait_nbits(0, 9, 200);
    rst_a = 1'b1;
    tick();
    check("midrst_sftclk", if_a.Sftclk, 0);
    check("midrst_sdout", if_a.SDout, 0);
    check("midrst_lchclk", if_a.Lchclk, 0);
    check("midrst_srst_n", if_a.Srst_n, 0);
    check("midrst_cur", if_a.cur_digit, 0);
    repeat (2) tick();
    check("midrst_no_latch", latch_cnt[0] - base, 0);
    exp_q.push_back(model_word(0, {16'h0, dg[15:0]}, dp, bl, DA));
    rst_a = 1'b0;
    wait_nbits(0, 1, 50);
    check("midrst_restart_digit0", if_a.cur_digit, 0);
    wait_latch(0, base + 1, 100);
    if_a.enable = 1'b0;
    wait_idle(0, 100);
    check("midrst_queue_drained", exp_q.size(), 0);

    // DIGITS = 1, SCK_DIV = 3
    if_b.digits = 4'h7; if_b.dp_en = 1'b1; if_b.blank = 1'b0;
    if_b.enable = 1'b1;
    wait_latch(1, 3, 600);
    wait_fd(1, 200);
    if_b.enable = 1'b0;
    wait_idle(1, 100);
    check("b_word_count", cap_b.size(), 3);
    for (int i = 0; i < cap_b.size(); i++) check("b_word", cap_b[i], model_word(0, 32'h7, 8'h1, 8'h0, DB));
    check("b_frame_done_each_digit", fd_cnt[1], 3);
    check("b_cur_digit", if_b.cur_digit, 0);

    // DIGITS = 8, SCK_DIV = 3
    dg = $urandom; dp = 8'($urandom_range(0, 255)); bl = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
    if_c.digits = dg; if_c.dp_en = dp; if_c.blank = bl;
    if_c.enable = 1'b1;
    wait_fd(2, 1500);
    if_c.enable = 1'b0;
    wait_idle(2, 100);
    check("c_word_count", cap_c.size(), 8);
    if (cap_c.size() == 8) begin
      check("c_digit0_sel", cap_c[0][15:8], 8'h80);
      for (int i = 0; i < 8; i++) check("c_word", cap_c[i], model_word(i, dg, dp, bl, DC));
    end
    check("c_frame_done_once", fd_cnt[2], 1);

    for (int k = 0; k < 3; k++) check("protocol_violations", viol[k], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
